keypad_word_assembler: RTL
==========================

# keypad_word_assembler

Downstream consumer of the 4×4 keypad scanner. Turns the scanner's level-type `done` / `q3_q0` key report into discrete key events, with release hold-off against bounce and against re-triggering while a key is held. Shifts each accepted 4-bit key code into a `DIGITS`-digit word and hands the completed word to a consumer over a valid/ready handshake.

## Interface
- `DIGITS`, default 4: hex digits per word; legal range 2..8.
- `HOLDOFF`, default 4: consecutive low samples of `done` required before the next key is accepted; legal range 1..15.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `done`  in  1  scanner key-valid level; high while a key is held and `q3_q0` is stable.
- `q3_q0`  in  4  scanner key code; sampled only when `done`=1.
- `word`  out  4*DIGITS  assembled word; most recent digit in bits [3:0].
- `count`  out  $clog2(DIGITS+1)  digits currently held in `word`.
- `ovalid`  out  1  `word` is complete and stable.
- `oready`  in  1  consumer accepts `word` on an edge where `ovalid`=1.

## Operation
- FSM states: IDLE (armed), HELD (wait for release), GAP (counting release samples), FULL (word offered).
- Reset, which overrides everything including mid-entry and mid-handshake, produces: state=HELD, `word`=0, `count`=0, `ovalid`=0, hold-off counter=0.
  - A key held across reset is never captured.
  - After reset, the first key is accepted only after `HOLDOFF` low samples of `done`.
- IDLE, `done`=1:
  - Accept the digit: `word` <= {`word`[4*DIGITS-5:0], `q3_q0`}, `count` <= `count`+1.
  - If the new count equals `DIGITS`, set `ovalid`=1 and go to FULL; otherwise go to HELD.
- IDLE, `done`=0: stay.
- HELD, `done`=0:
  - `HOLDOFF`=1: go to IDLE.
  - Otherwise: go to GAP with hold-off counter=1.
- HELD, `done`=1: stay.
- GAP, `done`=1: bounce; go to HELD. No digit is accepted.
- GAP, `done`=0:
  - If counter = `HOLDOFF`-1: go to IDLE.
  - Otherwise: counter +1.
- FULL:
  - All key activity is ignored.
  - On `oready`=1: `ovalid`=0, `word`=0, `count`=0, go to HELD. A key pressed during FULL therefore still needs release plus hold-off.
- `word` and `count` change only on digit acceptance, clear, handshake or reset.

## Timing
- All outputs are registered.
- Digit latency: the key is sampled on the first IDLE edge with `done`=1. `word` and `count` are visible after that edge, i.e. 1 cycle.
- `ovalid` rises on the same edge that shifts in the final digit.
- `ovalid` stays high and `word` stays frozen until the first edge with `oready`=1.
- `oready` while `ovalid`=0 has no effect.
- Minimum spacing between accepted keys: 1 held edge + `HOLDOFF` low edges.
- `reset` and `oready` high on the same edge: reset wins.

## Configuration
- `KEYPAD_CLEAR_EN` defined:
  - Code 4'hF accepted in IDLE is a clear key: `word` <= 0, `count` <= 0, go to HELD.
  - 4'hF is never stored and never raises `ovalid`.
- `KEYPAD_CLEAR_EN` undefined: 4'hF is an ordinary digit.

## Structure
- Shared package `keypad_pkg`:
  - state enum (IDLE, HELD, GAP, FULL);
  - `KEY_W`=4;
  - `KEY_CLEAR`=4'hF.
- One sub-module, `keypad_release_timer`: hold-off counter.
  - Inputs: `clock`, `reset`, `start`, `done`.
  - Output: `expired`.
- The FSM, shift register and handshake stay in the top module.

## Test plan
All scenarios use `DIGITS`=4, `HOLDOFF`=4.
- Reset with `done`=1 held across it for 3 cycles, then released -> `word`=16'h0000, `count`=0, `ovalid`=0; nothing is captured until 4 low samples of `done`.
- Keys 1,2,3,4, each `done` high 3 cycles then low 5, `oready`=0 -> `count` steps 1..4 one cycle after each press; `word`=16'h1234 and `ovalid`=1 after the 4th press. Pulsing `oready` then gives `word`=0, `count`=0, `ovalid`=0 on the next edge.
- Bounce: `q3_q0`=7, `done` pattern 1,1,0,0,1,0,0,0,0,0,0 -> exactly one digit captured, `word`=16'h0007, `count`=1.
- In FULL (`word`=16'h1234, `oready`=0), press key 9 -> `word` unchanged. Then `oready`=1 while 9 is still held -> cleared; 9 is not captured until released plus 4 low samples.
- Keys 5,6,F,8:
  - with `KEYPAD_CLEAR_EN` -> `word`=16'h0008, `count`=1, `ovalid`=0;
  - without -> `word`=16'h56F8, `ovalid`=1.
- After 2 digits (`word`=16'h0012), assert `reset` for 1 cycle -> all outputs 0 on that edge; the next accepted key requires `HOLDOFF` low samples.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad word assembler.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        GAP,
        FULL
    } state_t;

    localparam int KEY_W = 4;
    localparam int HOLD_W = 4;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hF;

endpackage

// File: rtl/keypad_word_assembler_timer.sv
// Release hold-off counter: counts consecutive low samples of done after start.
module keypad_release_timer
    import keypad_pkg::*;
#(
    parameter int HOLDOFF = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic done,
    output logic expired
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLDOFF - 1);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    assign expired = (cnt_q != '0) && (cnt_q == LAST);

    // A bounce (done high) or reaching the limit drops the count back to idle.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = HOLD_W'(1);
        end else if (done) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = expired ? '0 : cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_word_assembler.sv
// Keypad key-event filter, digit shifter and word handshake.
// Optional clear key (4'hF) enabled by defining KEYPAD_CLEAR_EN.
module keypad_word_assembler
    import keypad_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int HOLDOFF = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         done,
    input  logic [3:0]                   q3_q0,
    output logic [4*DIGITS-1:0]          word,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         ovalid,
    input  logic                         oready
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int WW = KEY_W * DIGITS;

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovalid_q, ovalid_d;
    logic [CW-1:0]   count_inc;
    logic            timer_start;
    logic            timer_expired;
    logic            is_clear;

`ifdef KEYPAD_CLEAR_EN
    assign is_clear = (q3_q0 == KEY_CLEAR);
`else
    assign is_clear = 1'b0;
`endif

    assign count_inc = count_q + CW'(1);

    keypad_release_timer #(
        .HOLDOFF (HOLDOFF)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .start   (timer_start),
        .done    (done),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        count_d     = count_q;
        ovalid_d    = ovalid_q;
        timer_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (done && is_clear) begin
                    word_d  = '0;
                    count_d = '0;
                    state_d = HELD;
                end else if (done) begin
                    word_d  = {word_q[WW-KEY_W-1:0], q3_q0};
                    count_d = count_inc;
                    if (count_inc == CW'(DIGITS)) begin
                        ovalid_d = 1'b1;
                        state_d  = FULL;
                    end else begin
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (!done) begin
                    if (HOLDOFF == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = GAP;
                        timer_start = 1'b1;
                    end
                end
            end
            GAP: begin
                if (done) begin
                    state_d = HELD;
                end else if (timer_expired) begin
                    state_d = IDLE;
                end
            end
            FULL: begin
                // Returning via HELD forces a key held here to be released first.
                if (oready) begin
                    ovalid_d = 1'b0;
                    word_d   = '0;
                    count_d  = '0;
                    state_d  = HELD;
                end
            end
            default: state_d = HELD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= HELD;
            word_q   <= '0;
            count_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            count_q  <= count_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign word   = word_q;
    assign count  = count_q;
    assign ovalid = ovalid_q;

endmodule
